// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap controller: exception/interrupt arbitration, trap strobe, flush and PC select
// Optional feature macro: TRAP_IRQ_SYNC_EN (2-flop irq synchronizers ahead of the edge detector)
module trap_ctrl #(
   parameter int NUM_IRQ        = 4,
   parameter int IRQ_CAUSE_BASE = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   input  logic [31:0]        pc,
   input  logic               exc_fetch_misalign,
   input  logic               exc_illegal,
   input  logic               exc_ebreak,
   input  logic               exc_load_misalign,
   input  logic               exc_store_misalign,
   input  logic               exc_ecall,
   input  logic               mret,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic [31:0]        csr_info,
   output logic               except,
   output logic               interrupt,
   output logic [31:0]        except_info,
   output logic               flush,
   output logic [1:0]         pc_sel,
   output logic               in_handler,
   output logic               double_fault,
   output logic [NUM_IRQ-1:0] irq_pending
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      TRAP = 2'b01,
      RET  = 2'b10
   } state_t;

   state_t             state_q;
   logic               except_q;
   logic               flush_q;
   logic [1:0]         pc_sel_q;
   logic [31:0]        info_q;
   logic               in_handler_q;
   logic               double_fault_q;

   logic [NUM_IRQ-1:0] irq_src;
   logic [NUM_IRQ-1:0] irq_prev_q;
   logic [NUM_IRQ-1:0] irq_rise;
   logic [NUM_IRQ-1:0] pending_q;
   logic [NUM_IRQ-1:0] pending_d;

   logic               sync_hit;
   logic [6:0]         sync_cause;
   logic [NUM_IRQ-1:0] irq_elig;
   logic               irq_hit;
   logic [6:0]         irq_cause;
   logic [NUM_IRQ-1:0] irq_clr_sel;
   logic [NUM_IRQ-1:0] irq_clr;
   logic               can_take;
   logic               take_trap;
   logic               take_irq;
   logic               take_ret;
   logic [7:0]         mstatus_new;
   logic [31:0]        info_d;
   logic               unused_ok;

`ifdef TRAP_IRQ_SYNC_EN
   logic [NUM_IRQ-1:0] irq_s1_q;
   logic [NUM_IRQ-1:0] irq_s2_q;

   // two-flop synchronizer for asynchronous interrupt lines
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_s1_q <= '0;
         irq_s2_q <= '0;
      end else begin
         irq_s1_q <= irq;
         irq_s2_q <= irq_s1_q;
      end
   end

   assign irq_src = irq_s2_q;
`else
   assign irq_src = irq;
`endif

   assign irq_rise = irq_src & ~irq_prev_q;

   // synchronous exception priority encoder, highest priority first
   always_comb begin
      sync_hit   = 1'b1;
      sync_cause = 7'd0;
      if (exc_fetch_misalign)      sync_cause = 7'd0;
      else if (exc_illegal)        sync_cause = 7'd2;
      else if (exc_ebreak)         sync_cause = 7'd3;
      else if (exc_load_misalign)  sync_cause = 7'd4;
      else if (exc_store_misalign) sync_cause = 7'd6;
      else if (exc_ecall)          sync_cause = 7'd11;
      else                         sync_hit   = 1'b0;
   end

   assign irq_elig = pending_q & csr_info[16 +: NUM_IRQ]
                   & {NUM_IRQ{csr_info[3] & ~in_handler_q & instr_valid}};

   // lowest-numbered eligible interrupt wins; scan downward so it is assigned last
   always_comb begin
      irq_hit     = 1'b0;
      irq_cause   = 7'd0;
      irq_clr_sel = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (irq_elig[i]) begin
            irq_hit        = 1'b1;
            irq_cause      = 7'(IRQ_CAUSE_BASE + i);
            irq_clr_sel    = '0;
            irq_clr_sel[i] = 1'b1;
         end
      end
   end

   // flags are only looked at in IDLE: TRAP/RET cycles carry a flushed instruction
   assign can_take  = (state_q == IDLE) & instr_valid;
   assign take_trap = can_take & (sync_hit | irq_hit);
   assign take_irq  = can_take & ~sync_hit & irq_hit;
   assign take_ret  = can_take & ~take_trap & mret & in_handler_q;

   assign irq_clr   = take_irq ? irq_clr_sel : '0;
   assign pending_d = (pending_q & ~irq_clr) | irq_rise;

   // MPIE takes the old MIE, MIE is cleared, the rest of the byte passes through
   assign mstatus_new = {csr_info[3], csr_info[6:4], 1'b0, csr_info[2:0]};
   assign info_d      = {~sync_hit, (sync_hit ? sync_cause : irq_cause), mstatus_new, pc[15:0]};

   // edge detector history and pending latches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_prev_q <= '0;
         pending_q  <= '0;
      end else begin
         irq_prev_q <= irq_src;
         pending_q  <= pending_d;
      end
   end

   // trap/return sequencer with registered strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         except_q       <= 1'b0;
         flush_q        <= 1'b0;
         pc_sel_q       <= 2'b00;
         info_q         <= '0;
         in_handler_q   <= 1'b0;
         double_fault_q <= 1'b0;
      end else begin
         except_q <= 1'b0;
         flush_q  <= 1'b0;
         pc_sel_q <= 2'b00;
         case (state_q)
            IDLE: begin
               if (take_trap) begin
                  state_q      <= TRAP;
                  except_q     <= 1'b1;
                  flush_q      <= 1'b1;
                  pc_sel_q     <= 2'b01;
                  info_q       <= info_d;
                  in_handler_q <= 1'b1;
                  if (sync_hit && in_handler_q) begin
                     double_fault_q <= 1'b1;
                  end
               end else if (take_ret) begin
                  state_q      <= RET;
                  flush_q      <= 1'b1;
                  pc_sel_q     <= 2'b10;
                  in_handler_q <= 1'b0;
               end
            end
            TRAP:    state_q <= IDLE;
            RET:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign except       = except_q;
   assign interrupt    = info_q[31];
   assign except_info  = info_q;
   assign flush        = flush_q;
   assign pc_sel       = pc_sel_q;
   assign in_handler   = in_handler_q;
   assign double_fault = double_fault_q;
   assign irq_pending  = pending_q;

   assign unused_ok = ^{pc[31:16], csr_info[31:16], csr_info[15:8]};

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - randomized self-checking bench for trap_ctrl against a behavioural model
module tb_trap_ctrl;

   localparam int NUM_IRQ = 4;
   localparam int BASE    = 16;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               instr_valid;
   logic [31:0]        pc;
   logic               exc_fetch_misalign, exc_illegal, exc_ebreak;
   logic               exc_load_misalign, exc_store_misalign, exc_ecall;
   logic               mret;
   logic [NUM_IRQ-1:0] irq;
   logic [31:0]        csr_info;
   logic               except, interrupt, flush, in_handler, double_fault;
   logic [31:0]        except_info;
   logic [1:0]         pc_sel;
   logic [NUM_IRQ-1:0] irq_pending;

   always #5 clk = ~clk;

   trap_ctrl #(.NUM_IRQ(NUM_IRQ), .IRQ_CAUSE_BASE(BASE)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .pc(pc),
      .exc_fetch_misalign(exc_fetch_misalign), .exc_illegal(exc_illegal),
      .exc_ebreak(exc_ebreak), .exc_load_misalign(exc_load_misalign),
      .exc_store_misalign(exc_store_misalign), .exc_ecall(exc_ecall),
      .mret(mret), .irq(irq), .csr_info(csr_info),
      .except(except), .interrupt(interrupt), .except_info(except_info),
      .flush(flush), .pc_sel(pc_sel), .in_handler(in_handler),
      .double_fault(double_fault), .irq_pending(irq_pending)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // behavioural model state
   bit                 e_except, e_flush, m_in_handler, m_dfault;
   int                 e_pcsel;
   logic [31:0]        e_info;
   bit [NUM_IRQ-1:0]   m_pend;
   bit [NUM_IRQ-1:0]   m_hist [3];

   task automatic model_reset();
      e_except = 0; e_flush = 0; e_pcsel = 0; e_info = '0;
      m_in_handler = 0; m_dfault = 0; m_pend = '0;
      for (int k = 0; k < 3; k++) m_hist[k] = '0;
   endtask

   // evaluate one clock edge from the inputs currently applied
   task automatic model_edge();
      int               cause;
      int               clr_idx;
      bit               is_irq;
      bit               ret;
      bit               busy;
      bit [NUM_IRQ-1:0] rise;
      bit               flags [6];
      int               codes [6];
      logic [7:0]       mst;
      codes = '{0, 2, 3, 4, 6, 11};
      flags = '{exc_fetch_misalign, exc_illegal, exc_ebreak,
                exc_load_misalign, exc_store_misalign, exc_ecall};
      busy    = e_flush;
      cause   = -1;
      clr_idx = -1;
      is_irq  = 0;
      if (!busy && instr_valid) begin
         for (int k = 0; k < 6; k++)
            if (flags[k] && cause < 0) cause = codes[k];
         if (cause < 0 && csr_info[3] && !m_in_handler)
            for (int i = 0; i < NUM_IRQ; i++)
               if (cause < 0 && m_pend[i] && csr_info[16+i]) begin
                  cause = BASE + i; is_irq = 1; clr_idx = i;
               end
      end
      ret = !busy && instr_valid && cause < 0 && mret && m_in_handler;
`ifdef TRAP_IRQ_SYNC_EN
      rise = m_hist[1] & ~m_hist[2];
`else
      rise = irq & ~m_hist[0];
`endif
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = irq;
      if (clr_idx >= 0) m_pend[clr_idx] = 1'b0;
      m_pend   = m_pend | rise;
      e_except = (cause >= 0);
      e_flush  = e_except || ret;
      e_pcsel  = e_except ? 1 : (ret ? 2 : 0);
      if (e_except) begin
         mst    = (csr_info[7:0] & 8'h77) | (csr_info[3] ? 8'h80 : 8'h00);
         e_info = {is_irq, 7'(cause), mst, pc[15:0]};
         if (!is_irq && m_in_handler) m_dfault = 1;
         m_in_handler = 1;
      end
      if (ret) m_in_handler = 0;
   endtask

   task automatic compare_all();
      check_eq("except",       32'(except),       32'(e_except));
      check_eq("flush",        32'(flush),        32'(e_flush));
      check_eq("pc_sel",       32'(pc_sel),       32'(e_pcsel));
      check_eq("except_info",  except_info,       e_info);
      check_eq("interrupt",    32'(interrupt),    32'(e_info[31]));
      check_eq("in_handler",   32'(in_handler),   32'(m_in_handler));
      check_eq("double_fault", 32'(double_fault), 32'(m_dfault));
      check_eq("irq_pending",  32'(irq_pending),  32'(m_pend));
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic clear_inputs();
      instr_valid = 0; pc = '0; mret = 0;
      exc_fetch_misalign = 0; exc_illegal = 0; exc_ebreak = 0;
      exc_load_misalign = 0; exc_store_misalign = 0; exc_ecall = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_except"},  32'(except),      32'd0);
      check_eq({tag, "_flush"},   32'(flush),       32'd0);
      check_eq({tag, "_handler"}, 32'(in_handler),  32'd0);
      check_eq({tag, "_pending"}, 32'(irq_pending), 32'd0);
      check_eq({tag, "_info"},    except_info,      32'd0);
      check_eq({tag, "_dfault"},  32'(double_fault), 32'd0);
   endtask

   task automatic leave_handler();
      clear_inputs();
      tick();
      instr_valid = 1; mret = 1; pc = 32'h40;
      tick();
      clear_inputs();
      tick();
   endtask

   initial begin
      rst_n = 0; irq = '0; csr_info = '0;
      clear_inputs();
      exc_illegal = 1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1;

      // illegal instruction straight out of reset
      instr_valid = 1; pc = 32'h0000_0124;
      tick();
      check_eq("tp1_info", except_info, 32'h0200_0124);
      check_eq("tp1_pcsel", 32'(pc_sel), 32'd1);
      leave_handler();

      // enabled interrupt on line 1
      csr_info = 32'h0002_0008;
      irq = 4'b0010;
      tick();
      irq = '0;
      repeat (3) tick();
      instr_valid = 1; pc = 32'h200;
      tick();
      check_eq("tp2_info", except_info, 32'h9180_0200);
      check_eq("tp2_pend1", 32'(irq_pending[1]), 32'd0);
      leave_handler();

      // ecall + illegal + pending irq0: illegal wins, irq0 stays pending
      csr_info = 32'h0003_0008;
      irq = 4'b0001;
      tick();
      irq = '0;
      repeat (3) tick();
      instr_valid = 1; pc = 32'h280; exc_ecall = 1; exc_illegal = 1;
      tick();
      check_eq("tp3_cause", 32'(except_info[30:24]), 32'd2);
      check_eq("tp3_pend0", 32'(irq_pending[0]), 32'd1);
      clear_inputs();
      instr_valid = 1; pc = 32'h284;
      repeat (4) tick();
      check_eq("tp3_no_irq", 32'(except), 32'd0);

      // mret returns; mret while idle does nothing
      csr_info = '0;
      mret = 1;
      tick();
      check_eq("tp4_ret_pcsel", 32'(pc_sel), 32'd2);
      check_eq("tp4_ret_handler", 32'(in_handler), 32'd0);
      tick();
      tick();
      check_eq("tp4_idle_flush", 32'(flush), 32'd0);

      // nested sync exception sets sticky double fault
      clear_inputs();
      instr_valid = 1; exc_ecall = 1; pc = 32'h2f0;
      tick();
      clear_inputs();
      tick();
      instr_valid = 1; exc_load_misalign = 1; pc = 32'h300;
      tick();
      check_eq("tp5_cause", 32'(except_info[30:24]), 32'd4);
      check_eq("tp5_mepc", 32'(except_info[15:0]), 32'h300);
      clear_inputs();
      repeat (3) tick();
      check_eq("tp5_sticky", 32'(double_fault), 32'd1);

      // reset dropped in the TRAP cycle
      csr_info = 32'h0001_0008;
      irq = 4'b0001;
      tick();
      irq = '0;
      repeat (3) tick();
      instr_valid = 1; exc_store_misalign = 1; pc = 32'h3a0;
      tick();
      check_eq("tp6_strobe", 32'(except), 32'd1);
      rst_n = 0;
      #1;
      check_all_zero("tp6_reset");
      model_reset();
      clear_inputs();
      @(posedge clk);
      #1;
      rst_n = 1;

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         instr_valid        = ($urandom_range(0, 3) != 0);
         pc                 = $urandom;
         exc_fetch_misalign = ($urandom_range(0, 39) == 0);
         exc_illegal        = ($urandom_range(0, 29) == 0);
         exc_ebreak         = ($urandom_range(0, 29) == 0);
         exc_load_misalign  = ($urandom_range(0, 29) == 0);
         exc_store_misalign = ($urandom_range(0, 29) == 0);
         exc_ecall          = ($urandom_range(0, 29) == 0);
         mret               = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 3) == 0) irq = NUM_IRQ'($urandom);
         if ($urandom_range(0, 15) == 0) csr_info = $urandom | (($urandom_range(0, 2) != 0) ? 32'h8 : 32'h0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
